awb_gain_calc: RTL
==================

// Module: awb_gain_calc
// PURPOSE
//  Frame-level auto-white-balance gain engine for raw Bayer video. Accumulates per-channel
//  pixel sums (R, G0, G1, B) over a frame and computes fixed-point R and B gains normalised
//  to green. Sits between the raw-pixel front end and the WB multiplier stage.
//  Accumulation of frame N+1 overlaps the division for frame N.
// PARAMETERS
//  DW      8   pixel width
//  CNT_W   22  log2 of max pixels per channel; sum width SW = DW+CNT_W
//  FRAC    7   fractional bits of gain (Q.FRAC)
//  GW      18  gain output width
//  SM_SH   2   IIR smoothing shift (used only with AWB_SMOOTH_EN)
// PORTS
//  clk        in   1      clock
//  rst        in   1      asynchronous reset, active-high
//  sof        in   1      start-of-frame pulse; clears accumulators, samples bayer_pat
//  eof        in   1      end-of-frame pulse; snapshots sums, starts divide
//  pix_valid  in   1      pixel qualifier
//  pix_data   in   DW     raw pixel
//  pix_x      in   1      column LSB
//  pix_y      in   1      row LSB
//  bayer_pat  in   2      0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
//  gain_r     out  GW     red gain, Q.FRAC
//  gain_b     out  GW     blue gain, Q.FRAC
//  gain_valid out  1      1-cycle pulse when gain_r/gain_b update
//  busy       out  1      divider active
//  ovf        out  1      1-cycle pulse: eof arrived while busy, frame dropped
// BEHAVIOUR
//  Reset: all outputs 0; accumulators/snapshots 0; FSM IDLE.
//  Channel index = {pix_y^pat[1], pix_x^pat[0]}: 0 R, 1 G0, 2 G1, 3 B (pat sampled at sof).
//  Accumulate on pix_valid into SW-bit sums; saturate at all-ones, no wrap.
//  sof+pix_valid same cycle: sum restarts with that pixel. eof+pix_valid: pixel included.
//  eof with FSM IDLE: snapshot Sr, Sg=S_g0+S_g1 (SW+1 b), Sb; accumulators keep running until next sof.
//  eof with busy=1: no snapshot, ovf pulses, gains unchanged.
//  Gain: Q = floor((Sg<<FRAC) / (Sx<<1)), x in {r,b}; numerator width QW = SW+1+FRAC.
//  Q > 2^GW-1 or Sx==0 -> saturate to 2^GW-1.
//  FSM: IDLE -> LOAD_R(1) -> DIV_R(QW) -> LOAD_B(1) -> DIV_B(QW) -> DONE(1) -> IDLE.
//  gain_valid asserted in DONE, exactly 2*QW+3 cycles after the eof cycle; gains registered then.
//  busy = 1 in every state except IDLE.
//  Async rst mid-divide: abort, all outputs 0, next eof starts clean.
// CONFIGURATION
//  AWB_SMOOTH_EN defined: gain_x <= gain_x + ((Q - gain_x) >>> SM_SH) (signed, GW+1 b);
//    first update after reset loads Q directly.
//  AWB_SMOOTH_EN undefined: gain_x <= Q every frame.
// STRUCTURE
//  awb_pkg: bayer pattern enum, FSM state enum, channel-index constants, SW/QW localparams.
//  Sub-module awb_seq_div: restoring divider, 1 quotient bit/cycle,
//    params NW/DWID, ports start, numer, denom, quotient, done, div0.
// TESTING (DW=8, FRAC=7, GW=18, smoothing off)
//  4x4 flat frame, all pixels 100, RGGB -> gain_r=gain_b=128, gain_valid at eof+2*QW+3.
//  R=50, G=100, B=200, RGGB -> gain_r=256, gain_b=64.
//  Same pixel values with bayer_pat=BGGR -> gain_r=64, gain_b=256.
//  R=0 -> gain_r=18'h3FFFF, gain_b normal.
//  Second eof while busy -> ovf pulse 1 cycle, single gain_valid, values of first frame.
//  rst asserted mid DIV_R -> gains 0, busy 0 same cycle; next frame yields correct gains.

Source files
------------

// File: rtl/awb_pkg.sv
// Shared types and constants for the auto-white-balance gain engine.
// Holds the Bayer pattern and FSM encodings plus default widths.
package awb_pkg;

   localparam int AWB_DW    = 8;
   localparam int AWB_CNT_W = 22;
   localparam int AWB_FRAC  = 7;
   localparam int AWB_GW    = 18;
   localparam int AWB_SM_SH = 2;
   localparam int AWB_SW    = AWB_DW + AWB_CNT_W;
   localparam int AWB_QW    = AWB_SW + 1 + AWB_FRAC;

   typedef enum logic [1:0] {
      PAT_RGGB = 2'd0,
      PAT_GRBG = 2'd1,
      PAT_GBRG = 2'd2,
      PAT_BGGR = 2'd3
   } awb_pat_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_R = 3'd1,
      ST_DIV_R  = 3'd2,
      ST_LOAD_B = 3'd3,
      ST_DIV_B  = 3'd4,
      ST_DONE   = 3'd5
   } awb_state_e;

   localparam logic [1:0] CH_R  = 2'd0;
   localparam logic [1:0] CH_G0 = 2'd1;
   localparam logic [1:0] CH_G1 = 2'd2;
   localparam logic [1:0] CH_B  = 2'd3;

endpackage

// File: rtl/awb_seq_div.sv
// Restoring divider, one quotient bit per clock.
// done pulses in the cycle after the final iteration, quotient valid then.
module awb_seq_div #(
   parameter int NW   = 38,
   parameter int DWID = 31
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [NW-1:0]   numer,
   input  logic [DWID-1:0] denom,
   output logic [NW-1:0]   quotient,
   output logic            done,
   output logic            div0
);

   localparam int CW = $clog2(NW + 1);

   logic [DWID-1:0] d;
   logic [DWID-1:0] rem;
   logic [CW-1:0]   cnt;
   logic [DWID:0]   r_sh;
   logic [DWID:0]   diff;
   logic            ge;

   assign r_sh = {rem, quotient[NW-1]};
   assign diff = r_sh - {1'b0, d};
   assign ge   = r_sh >= {1'b0, d};

   // Shift numerator bits into the partial remainder, subtracting when it fits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d        <= '0;
         rem      <= '0;
         quotient <= '0;
         cnt      <= '0;
         done     <= 1'b0;
         div0     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            d        <= denom;
            rem      <= '0;
            quotient <= numer;
            cnt      <= CW'(NW);
            div0     <= (denom == '0);
         end else if (cnt != '0) begin
            cnt      <= cnt - CW'(1);
            done     <= (cnt == CW'(1));
            quotient <= {quotient[NW-2:0], ge};
            rem      <= ge ? diff[DWID-1:0] : r_sh[DWID-1:0];
         end
      end
   end

endmodule

// File: rtl/awb_gain_calc.sv
// Frame-level AWB gain engine: per-channel Bayer sums, R/B gains vs green.
// Optional IIR smoothing of the gains is enabled by defining AWB_SMOOTH_EN.
module awb_gain_calc
   import awb_pkg::*;
#(
   parameter int DW    = AWB_DW,
   parameter int CNT_W = AWB_CNT_W,
   parameter int FRAC  = AWB_FRAC,
   parameter int GW    = AWB_GW
`ifdef AWB_SMOOTH_EN
   ,
   parameter int SM_SH = AWB_SM_SH
`endif
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sof,
   input  logic          eof,
   input  logic          pix_valid,
   input  logic [DW-1:0] pix_data,
   input  logic          pix_x,
   input  logic          pix_y,
   input  logic [1:0]    bayer_pat,
   output logic [GW-1:0] gain_r,
   output logic [GW-1:0] gain_b,
   output logic          gain_valid,
   output logic          busy,
   output logic          ovf
);

   localparam int SW = DW + CNT_W;
   localparam int QW = SW + 1 + FRAC;

   awb_state_e state, state_nxt;

   logic [1:0]    pat_q;
   logic [1:0]    pat_cur;
   logic [1:0]    ch;
   logic [SW-1:0] acc     [4];
   logic [SW-1:0] acc_nxt [4];
   logic [SW:0]   acc_sum [4];
   logic [SW-1:0] sr;
   logic [SW-1:0] sb;
   logic [SW:0]   sg;
   logic [SW:0]   sg_nxt;
   logic          eof_take;
   logic          div_start;
   logic          div_done;
   logic          div_zero;
   logic [QW-1:0] div_numer;
   logic [SW:0]   div_denom;
   logic [QW-1:0] div_quot;
   logic [GW-1:0] q_sat;
   logic [GW-1:0] gr_q;
`ifdef AWB_SMOOTH_EN
   logic          seeded;
`endif

   function automatic logic [GW-1:0] gain_sat(
      input logic [QW-1:0] q,
      input logic          z
   );
      if (z || (|q[QW-1:GW]))
         return '1;
      return q[GW-1:0];
   endfunction

`ifdef AWB_SMOOTH_EN
   function automatic logic [GW-1:0] smooth(
      input logic [GW-1:0] g,
      input logic [GW-1:0] q
   );
      logic signed [GW:0] df;
      df = $signed({1'b0, q}) - $signed({1'b0, g});
      df = df >>> SM_SH;
      return GW'($signed({1'b0, g}) + df);
   endfunction
`endif

   // The sof pixel uses the live pattern; later pixels use the latched one
   assign pat_cur  = sof ? bayer_pat : pat_q;
   assign ch       = {pix_y ^ pat_cur[1], pix_x ^ pat_cur[0]};
   assign eof_take = eof && (state == ST_IDLE);
   assign sg_nxt   = {1'b0, acc_nxt[CH_G0]} + {1'b0, acc_nxt[CH_G1]};

   // Divider operands: live sums at eof for R, snapshot for B
   assign div_numer = {(state == ST_IDLE) ? sg_nxt : sg, {FRAC{1'b0}}};
   assign div_denom = {(state == ST_IDLE) ? acc_nxt[CH_R] : sb, 1'b0};
   assign q_sat     = gain_sat(div_quot, div_zero);

   // Latch the Bayer pattern at start of frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pat_q <= '0;
      else if (sof)
         pat_q <= bayer_pat;
   end

   // Next accumulator values: restart on sof, saturating add of the pixel
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         acc_nxt[i] = sof ? '0 : acc[i];
         acc_sum[i] = {1'b0, acc_nxt[i]} + (SW+1)'(pix_data);
         if (pix_valid && (ch == 2'(i)))
            acc_nxt[i] = acc_sum[i][SW] ? '1 : acc_sum[i][SW-1:0];
      end
   end

   // Channel accumulators keep running across eof until the next sof
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++)
            acc[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++)
            acc[i] <= acc_nxt[i];
      end
   end

   // Snapshot frame sums (eof pixel included) when the divider is free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
         sg <= '0;
         sb <= '0;
      end else if (eof_take) begin
         sr <= acc_nxt[CH_R];
         sg <= sg_nxt;
         sb <= acc_nxt[CH_B];
      end
   end

   awb_seq_div #(
      .NW   (QW),
      .DWID (SW + 1)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .numer    (div_numer),
      .denom    (div_denom),
      .quotient (div_quot),
      .done     (div_done),
      .div0     (div_zero)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // FSM next-state: R divide, then B divide, then one publish cycle
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (eof) state_nxt = ST_LOAD_R;
         ST_LOAD_R: state_nxt = ST_DIV_R;
         ST_DIV_R:  if (div_done) state_nxt = ST_LOAD_B;
         ST_LOAD_B: state_nxt = ST_DIV_B;
         ST_DIV_B:  if (div_done) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs: status flags and divider launches
   always_comb begin
      busy       = (state != ST_IDLE);
      gain_valid = (state == ST_DONE);
      div_start  = ((state == ST_IDLE) && eof) ||
                   ((state == ST_DIV_R) && div_done);
   end

   // Dropped-frame pulse when eof lands while a divide is in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ovf <= 1'b0;
      else
         ovf <= eof && (state != ST_IDLE);
   end

   // R result parks in gr_q so both gains publish together on entering DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gr_q   <= '0;
         gain_r <= '0;
         gain_b <= '0;
`ifdef AWB_SMOOTH_EN
         seeded <= 1'b0;
`endif
      end else begin
         if ((state == ST_DIV_R) && div_done)
            gr_q <= q_sat;
         if ((state == ST_DIV_B) && div_done) begin
`ifdef AWB_SMOOTH_EN
            seeded <= 1'b1;
            if (!seeded) begin
               gain_r <= gr_q;
               gain_b <= q_sat;
            end else begin
               gain_r <= smooth(gain_r, gr_q);
               gain_b <= smooth(gain_b, q_sat);
            end
`else
            gain_r <= gr_q;
            gain_b <= q_sat;
`endif
         end
      end
   end

endmodule
